// File: rtl/mips_alu_pkg.sv
// Shared definitions for the R-type ALU sequencer: ALU op codes, funct codes,
// instruction field positions and the sequencer state encoding.
package mips_alu_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_XNOR = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_SLLV = 3'b111;

    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_XNOR = 6'b100111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLLV = 6'b000100;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_READ   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    // Only the arithmetic ops produce meaningful carry/overflow.
    function automatic logic op_has_cv(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational R-type decoder: opcode/funct to {legal, alu_op}.
// Kept standalone so the main control unit can reuse it.
module mips_alu_decode
    import mips_alu_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic       legal_o,
    output logic [2:0] alu_op_o
);

    always_comb begin
        legal_o  = 1'b0;
        alu_op_o = ALU_AND;
        if (opcode_i == 6'd0) begin
            legal_o = 1'b1;
            case (funct_i)
                FN_AND:  alu_op_o = ALU_AND;
                FN_OR:   alu_op_o = ALU_OR;
                FN_XOR:  alu_op_o = ALU_XOR;
                FN_XNOR: alu_op_o = ALU_XNOR;
                FN_ADD:  alu_op_o = ALU_ADD;
                FN_SUB:  alu_op_o = ALU_SUB;
                FN_SLT:  alu_op_o = ALU_SLT;
                FN_SLLV: alu_op_o = ALU_SLLV;
                default: legal_o  = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/mips_alu_seq.sv
// Five-state sequencer running one R-type instruction at a time on the shared
// ALU: IDLE -> DECODE -> READ -> EXEC -> WB, with flag status register.
module mips_alu_seq
    import mips_alu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          inst_valid_i,
    output logic          inst_ready_o,
    input  logic [31:0]   inst_i,
    output logic [RW-1:0] rf_raddr_a_o,
    output logic [RW-1:0] rf_raddr_b_o,
    input  logic [DW-1:0] rf_rdata_a_i,
    input  logic [DW-1:0] rf_rdata_b_i,
    output logic [DW-1:0] alu_a_o,
    output logic [DW-1:0] alu_b_o,
    output logic [2:0]    alu_op_o,
    input  logic [DW-1:0] alu_f_i,
    input  logic          alu_cf_i,
    input  logic          alu_zf_i,
    input  logic          alu_of_i,
    output logic          rf_we_o,
    output logic [RW-1:0] rf_waddr_o,
    output logic [DW-1:0] rf_wdata_o,
    output logic [2:0]    flags_o,
    output logic          done_o,
    output logic          illegal_o
);

    state_e        state_q, state_d;
    logic [5:0]    opc_q, fn_q;
    logic [RW-1:0] rs_q, rt_q, rd_q;
    logic [DW-1:0] alu_a_q, alu_b_q, res_q;
    logic [2:0]    alu_op_q, flg_cap_q, flags_q;
    logic          dec_legal, accept, cv;
    logic [2:0]    dec_op;

    mips_alu_decode u_dec (
        .opcode_i (opc_q),
        .funct_i  (fn_q),
        .legal_o  (dec_legal),
        .alu_op_o (dec_op)
    );

    assign accept = inst_valid_i && (state_q == ST_IDLE);
    assign cv     = op_has_cv(alu_op_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (inst_valid_i) state_d = ST_DECODE;
            ST_DECODE: state_d = dec_legal ? ST_READ : ST_IDLE;
            ST_READ:   state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_WB;
            ST_WB:     state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            opc_q     <= '0;
            fn_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            res_q     <= '0;
            flg_cap_q <= '0;
            flags_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                opc_q <= inst_i[OPC_MSB:OPC_LSB];
                fn_q  <= inst_i[FN_MSB:FN_LSB];
                rs_q  <= inst_i[RS_MSB:RS_LSB];
                rt_q  <= inst_i[RT_MSB:RT_LSB];
                rd_q  <= inst_i[RD_MSB:RD_LSB];
            end
            if (state_q == ST_READ) begin
                alu_a_q  <= rf_rdata_a_i;
                alu_b_q  <= rf_rdata_b_i;
                alu_op_q <= dec_op;
            end
            // Carry/overflow are meaningless for logic/compare/shift ops.
            if (state_q == ST_EXEC) begin
                res_q     <= alu_f_i;
                flg_cap_q <= {alu_cf_i & cv, alu_zf_i, alu_of_i & cv};
            end
            if (state_q == ST_WB) flags_q <= flg_cap_q;
        end
    end

    assign inst_ready_o = (state_q == ST_IDLE);
    assign illegal_o    = (state_q == ST_DECODE) && !dec_legal;
    assign done_o       = (state_q == ST_WB);
    assign rf_we_o      = done_o && (rd_q != '0);
    assign rf_raddr_a_o = rs_q;
    assign rf_raddr_b_o = rt_q;
    assign rf_waddr_o   = rd_q;
    assign rf_wdata_o   = res_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_op_o     = alu_op_q;
    assign flags_o      = flags_q;

endmodule

// File: tb/tb_mips_alu_seq.sv
// Bench for mips_alu_seq: register file and ALU environment models plus an
// instruction-level reference that predicts operands, result and flags.
module tb_mips_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid, inst_ready;
    logic [31:0] inst;
    logic [4:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [31:0] rf_rdata_a, rf_rdata_b, alu_a, alu_b, alu_f, rf_wdata;
    logic [2:0]  alu_op, flags;
    logic        alu_cf, alu_zf, alu_of, rf_we, done, illegal;

    logic [31:0] rf [32];
    logic [31:0] exp_rf [32];
    logic [2:0]  exp_flags;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_q[$];

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    always #5 clk = ~clk;

    mips_alu_seq #(.DW(32), .RW(5)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .inst_valid_i(inst_valid), .inst_ready_o(inst_ready), .inst_i(inst),
        .rf_raddr_a_o(rf_raddr_a), .rf_raddr_b_o(rf_raddr_b),
        .rf_rdata_a_i(rf_rdata_a), .rf_rdata_b_i(rf_rdata_b),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
        .alu_f_i(alu_f), .alu_cf_i(alu_cf), .alu_zf_i(alu_zf), .alu_of_i(alu_of),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .flags_o(flags), .done_o(done), .illegal_o(illegal)
    );

    // Environment: combinational-read register file and shared ALU.
    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];
    always @(posedge clk) if (rf_we) rf[rf_waddr] <= rf_wdata;

    always_comb begin
        alu_f  = '0;
        alu_cf = 1'b1;  // non-arithmetic ops report junk CF/OF so masking is exercised
        alu_of = 1'b1;
        case (alu_op)
            3'd0: alu_f = alu_a & alu_b;
            3'd1: alu_f = alu_a | alu_b;
            3'd2: alu_f = alu_a ^ alu_b;
            3'd3: alu_f = ~(alu_a ^ alu_b);
            3'd4: begin
                {alu_cf, alu_f} = {1'b0, alu_a} + {1'b0, alu_b};
                alu_of = (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            3'd5: begin
                {alu_cf, alu_f} = {1'b0, alu_a} - {1'b0, alu_b};
                alu_of = (alu_a[31] != alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            3'd6: alu_f = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_f = alu_b << alu_a[4:0];
        endcase
        alu_zf = (alu_f == 32'd0);
    end

    always @(posedge clk) begin
        if (inst_valid && inst_ready && rst_n) acc_q.push_back(cyc);
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) if (rst_n === 1'b1) begin
        chk("done_and_illegal", {31'd0, done & illegal}, 32'd0);
        chk("we_outside_wb", {31'd0, rf_we & ~done}, 32'd0);
    end

    function automatic logic [31:0] mk(input logic [5:0] opc, input logic [4:0] rs, rt, rd,
                                       input logic [5:0] fn);
        return {opc, rs, rt, rd, 5'd0, fn};
    endfunction

    // Reference semantics of one instruction, from the instruction-set rules.
    task automatic ref_exec(input logic [5:0] opc, fn, input logic [31:0] a, b,
                            output bit legal, output logic [2:0] op,
                            output logic [31:0] res, output logic [2:0] fl);
        longint s;
        bit cf = 0, of = 0;
        legal = (opc == 6'd0);
        op = 3'd0;
        res = 32'd0;
        case (fn)
            6'h24: begin op = 3'd0; res = a & b; end
            6'h25: begin op = 3'd1; res = a | b; end
            6'h26: begin op = 3'd2; res = a ^ b; end
            6'h27: begin op = 3'd3; res = ~(a ^ b); end
            6'h20: begin
                op = 3'd4; res = a + b;
                cf = (longint'(a) + longint'(b)) > 64'sd4294967295;
                s  = longint'($signed(a)) + longint'($signed(b));
                of = (s > SMAX) || (s < SMIN);
            end
            6'h22: begin
                op = 3'd5; res = a - b;
                cf = a < b;
                s  = longint'($signed(a)) - longint'($signed(b));
                of = (s > SMAX) || (s < SMIN);
            end
            6'h2a: begin op = 3'd6; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
            6'h04: begin op = 3'd7; res = b << a[4:0]; end
            default: legal = 0;
        endcase
        fl = {cf, res == 32'd0, of};
    endtask

    task automatic set_reg(input int i, input logic [31:0] v);
        rf[i] = v;
        exp_rf[i] = v;
    endtask

    // Issue one instruction from IDLE (#1 after an edge) and follow it to retirement.
    task automatic run_inst(input string tag, input logic [31:0] ins);
        bit legal;
        logic [2:0] op, fl;
        logic [31:0] res, a, b;
        logic [4:0] rs, rt, rd;
        rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        a = exp_rf[rs]; b = exp_rf[rt];
        ref_exec(ins[31:26], ins[5:0], a, b, legal, op, res, fl);
        chk({tag, ".ready"}, {31'd0, inst_ready}, 32'd1);
        inst_valid = 1'b1; inst = ins;
        @(posedge clk); #1;
        inst_valid = 1'b0; inst = $urandom;
        chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, !legal});
        chk({tag, ".ready_busy"}, {31'd0, inst_ready}, 32'd0);
        if (!legal) begin
            @(posedge clk); #1;
            chk({tag, ".ready_after_ill"}, {31'd0, inst_ready}, 32'd1);
            chk({tag, ".flags_kept"}, {29'd0, flags}, {29'd0, exp_flags});
            return;
        end
        @(posedge clk); #1;
        chk({tag, ".raddr_a"}, {27'd0, rf_raddr_a}, {27'd0, rs});
        chk({tag, ".raddr_b"}, {27'd0, rf_raddr_b}, {27'd0, rt});
        @(posedge clk); #1;
        chk({tag, ".alu_a"}, alu_a, a);
        chk({tag, ".alu_b"}, alu_b, b);
        chk({tag, ".alu_op"}, {29'd0, alu_op}, {29'd0, op});
        @(posedge clk); #1;
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        chk({tag, ".we"}, {31'd0, rf_we}, {31'd0, rd != 5'd0});
        chk({tag, ".waddr"}, {27'd0, rf_waddr}, {27'd0, rd});
        chk({tag, ".wdata"}, rf_wdata, res);
        chk({tag, ".flags_old"}, {29'd0, flags}, {29'd0, exp_flags});
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, ".ready_back"}, {31'd0, inst_ready}, 32'd1);
        chk({tag, ".flags"}, {29'd0, flags}, {29'd0, fl});
        exp_flags = fl;
        if (rd != 5'd0) exp_rf[rd] = res;
        chk({tag, ".rf_rd"}, rf[rd], exp_rf[rd]);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] fns [8];
        bit legal;
        logic [2:0] op, fl1, fl2;
        logic [31:0] r1, r2;
        logic [4:0] rs, rt, rd;
        logic [5:0] opc, fn;
        fns = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h20, 6'h22, 6'h2a, 6'h04};
        for (int i = 0; i < 32; i++) set_reg(i, (i == 0) ? 32'd0 : $urandom);
        exp_flags = 3'b000;

        // Reset
        rst_n = 1'b0; inst_valid = 1'b0; inst = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", {31'd0, inst_ready}, 32'd1);
        chk("rst.flags", {29'd0, flags}, 32'd0);
        chk("rst.ctl", {29'd0, rf_we, done, illegal}, 32'd0);
        chk("rst.alu_a", alu_a, 32'd0);
        chk("rst.alu_b", alu_b, 32'd0);
        chk("rst.alu_op", {29'd0, alu_op}, 32'd0);
        chk("rst.raddr", {22'd0, rf_raddr_a, rf_raddr_b}, 32'd0);
        chk("rst.waddr", {27'd0, rf_waddr}, 32'd0);
        chk("rst.wdata", rf_wdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        set_reg(1, 32'h7FFF_FFFF); set_reg(2, 32'h0000_0001);
        run_inst("add_ovf", mk(6'd0, 5'd1, 5'd2, 5'd3, 6'h20));
        chk("add_ovf.r3", rf[3], 32'h8000_0000);
        chk("add_ovf.flags_abs", {29'd0, flags}, 32'b001);
        set_reg(5, 32'd5); set_reg(6, 32'd5);
        run_inst("sub_zero", mk(6'd0, 5'd5, 5'd6, 5'd4, 6'h22));
        chk("sub_zero.flags_abs", {29'd0, flags}, 32'b010);
        set_reg(20, 32'hF0); set_reg(21, 32'h0F);
        run_inst("and_mask", mk(6'd0, 5'd20, 5'd21, 5'd22, 6'h24));
        chk("and_mask.flags_abs", {29'd0, flags}, 32'b010);
        set_reg(8, 32'd4); set_reg(9, 32'd1);
        run_inst("sllv_r0", mk(6'd0, 5'd8, 5'd9, 5'd0, 6'h04));
        chk("sllv_r0.flags_abs", {29'd0, flags}, 32'b000);
        chk("sllv_r0.r0", rf[0], 32'd0);
        run_inst("ill_lw", mk(6'h23, 5'd1, 5'd2, 5'd3, 6'h20));
        run_inst("ill_fn18", mk(6'd0, 5'd1, 5'd2, 5'd3, 6'h18));
        chk("ill.r3", rf[3], 32'h8000_0000);

        // Randomized instruction stream
        for (int n = 0; n < 30; n++) begin
            rs = $urandom; rt = $urandom; rd = $urandom;
            opc = ($urandom_range(7) == 0) ? 6'($urandom_range(63, 1)) : 6'd0;
            fn = ($urandom_range(5) == 0) ? 6'($urandom) : fns[$urandom_range(7)];
            if (rt != 0 && $urandom_range(3) == 0) set_reg(rt, exp_rf[rs]);
            run_inst($sformatf("rnd%0d", n), mk(opc, rs, rt, rd, fn));
        end

        // Back-to-back with inst_valid held high
        set_reg(10, 32'd100); set_reg(11, 32'd23);
        ref_exec(6'd0, 6'h20, 32'd100, 32'd23, legal, op, r1, fl1);
        ref_exec(6'd0, 6'h26, 32'd100, 32'd23, legal, op, r2, fl2);
        acc_q.delete();
        inst_valid = 1'b1; inst = mk(6'd0, 5'd10, 5'd11, 5'd12, 6'h20);
        for (int k = 0; k < 10; k++) begin
            if (acc_q.size() >= 1) break;
            @(posedge clk); #1;
        end
        inst = mk(6'd0, 5'd10, 5'd11, 5'd13, 6'h26);
        for (int k = 0; k < 10; k++) begin
            if (acc_q.size() >= 2) break;
            @(posedge clk); #1;
        end
        inst_valid = 1'b0;
        chk("b2b.accepts", acc_q.size(), 32'd2);
        if (acc_q.size() >= 2) chk("b2b.spacing", acc_q[1] - acc_q[0], 32'd5);
        repeat (4) @(posedge clk);
        #1;
        exp_rf[12] = r1; exp_rf[13] = r2; exp_flags = fl2;
        chk("b2b.r12", rf[12], r1);
        chk("b2b.r13", rf[13], r2);
        chk("b2b.flags", {29'd0, flags}, {29'd0, fl2});
        chk("b2b.ready", {31'd0, inst_ready}, 32'd1);

        // Reset during EXEC
        run_inst("add_pre_rst", mk(6'd0, 5'd1, 5'd2, 5'd3, 6'h20));
        set_reg(14, 32'h1234_5678);
        inst_valid = 1'b1; inst = mk(6'd0, 5'd1, 5'd2, 5'd14, 6'h20);
        @(posedge clk); #1;
        inst_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst.ready", {31'd0, inst_ready}, 32'd1);
        chk("mrst.flags", {29'd0, flags}, 32'd0);
        chk("mrst.we_done", {30'd0, rf_we, done}, 32'd0);
        chk("mrst.r14", rf[14], 32'h1234_5678);
        rst_n = 1'b1; exp_flags = 3'b000;
        @(posedge clk); #1;
        chk("mrst.idle", {30'd0, inst_ready, done}, 32'b10);
        run_inst("post_rst", mk(6'd0, 5'd5, 5'd6, 5'd15, 6'h2a));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_alu_seq.md
# mips_alu_seq

Multi-cycle sequencer that executes one R-type arithmetic/logic instruction at a time on the shared 32-bit ALU. It accepts an instruction word over a valid/ready handshake, decodes it to the 3-bit ALU operation code, reads both source operands from the register file, and holds the ALU inputs stable for a full execute cycle. It then writes the result back to the register file and latches the CF/ZF/OF flags into a status register. It sits between the instruction source and the register-file/ALU pair.

## Interface
- DW, 32, datapath width
- RW, 5, register address width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- inst_valid  in  1  instruction offered
- inst_ready  out  1  sequencer can accept (high only in IDLE)
- inst  in  32  instruction word: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0]
- rf_raddr_a / rf_raddr_b  out  RW  read addresses (rs / rt); combinational-read register file
- rf_rdata_a / rf_rdata_b  in  DW  read data
- alu_a / alu_b  out  DW  ALU operands (registered)
- alu_op  out  3  ALU operation code (registered)
- alu_f  in  DW  ALU result
- alu_cf / alu_zf / alu_of  in  1  ALU carry, zero and overflow
- rf_we  out  1  write enable (one-cycle pulse)
- rf_waddr  out  RW  write address (rd)
- rf_wdata  out  DW  write data
- flags  out  3  {CF, ZF, OF} status register
- done  out  1  one-cycle pulse, instruction retired
- illegal  out  1  one-cycle pulse, instruction rejected

## Operation
- Decode requires opcode == 0. Legal funct values and their codes:
  - 100100 AND -> 000
  - 100101 OR -> 001
  - 100110 XOR -> 010
  - 100111 XNOR -> 011
  - 100000 ADD -> 100
  - 100010 SUB -> 101
  - 101010 SLT -> 110
  - 000100 SLLV -> 111 (F = rt << rs)
- Any other opcode or funct is illegal.
- alu_a = rs data and alu_b = rt data for every operation.
- FSM states and transitions:
  - IDLE -> DECODE when inst_valid && inst_ready.
  - DECODE -> READ if legal; DECODE -> IDLE with illegal pulse otherwise.
  - READ -> EXEC -> WB -> IDLE.
- Instruction fields are captured on acceptance. inst is ignored outside IDLE.
- READ drives rf_raddr_a/b from the captured rs/rt, and operands are registered at the end of READ. alu_a/alu_b/alu_op then stay stable through EXEC and WB.
- alu_f and the flags are captured at the end of EXEC.
- Flag masking: CF and OF are forced to 0 unless alu_op is 100 or 101. ZF always comes from alu_zf.
- WB cycle:
  - rf_we = 1, rf_waddr = rd, rf_wdata = captured result.
  - The flags register updates at the end of WB.
  - done = 1.
- rd == 0: rf_we is suppressed, but done still pulses and flags still update.
- An illegal instruction leaves flags and register file untouched.

## Timing
- Reset values while rst_n is low at an edge:
  - state IDLE, inst_ready = 1.
  - rf_raddr_a/b, alu_a, alu_b, alu_op, rf_waddr, rf_wdata, flags = 0.
  - rf_we, done, illegal = 0.
- Reset mid-operation: the next edge returns to IDLE. No write, no done pulse, flags cleared.
- Legal instruction accepted at edge N:
  - DECODE during cycle N+1, READ N+2, EXEC N+3.
  - WB during N+4, with rf_we and done high.
  - inst_ready is high again in cycle N+5.
  - Throughput is one instruction per 5 cycles.
- Illegal instruction accepted at edge N: illegal is high in cycle N+1, and inst_ready is high in cycle N+2.
- inst_valid held high continuously: the next instruction is accepted at the first IDLE edge, with no bubble beyond IDLE.
- done and illegal are never high together. rf_we is never high outside WB.

## Structure
- Shared package mips_alu_pkg:
  - ALU_OP localparams (ALU_AND … ALU_SLLV).
  - funct localparams.
  - FSM state encoding (3-bit).
  - Field bit positions.
- Sub-module mips_alu_decode: combinational funct/opcode -> {legal, alu_op[2:0]}. It is reusable by the main control unit.
- The top level holds the FSM, capture registers, flag masking and write-back.

## Test plan
- Reset with rst_n low for 2 cycles, then release -> all outputs 0 except inst_ready = 1; flags = 000.
- ADD with rs = 1 holding 0x7FFFFFFF, rt = 2 holding 0x00000001, rd = 3 -> WB at N+4 writes 0x80000000 to r3; flags = {0,0,1}; done is a single pulse.
- SUB with 5 - 5 into rd = 4 -> r4 = 0; flags = {CF per ALU, 1, 0}. Then AND with 0xF0 & 0x0F -> ZF = 1, CF = 0, OF = 0 (masked).
- SLLV with rs = 4, rt = 0x00000001, rd = 0 -> no rf_we pulse; done pulses; flags ZF = 0.
- Opcode 0x23 (lw), or funct 0x18 -> illegal pulses in cycle N+1; inst_ready returns in N+2; no rf_we; flags unchanged.
- rst_n asserted during EXEC -> no rf_we or done; state IDLE and flags 000 next cycle. Back-to-back valid instructions -> accepted every 5 cycles.
